// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential signed divider.
// Holds the controller state encoding and the default operand width.
package seq_div_pkg;

  localparam int DEF_BIT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_DIVIDE = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/seq_div.sv
// Multi-cycle signed divider: 2W-bit dividend by W-bit divisor.
// Restoring division on magnitudes, signs applied afterwards.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2*BIT_WIDTH-1:0]   dividend,
  input  logic [BIT_WIDTH-1:0]     divisor,
  output logic                     busy,
  output logic                     done,
  output logic [2*BIT_WIDTH-1:0]   quotient,
  output logic [BIT_WIDTH-1:0]     remainder,
  output logic                     div_by_zero,
  output logic                     overflow
);

  localparam int BW = BIT_WIDTH;
  localparam int QW = 2 * BIT_WIDTH;
  localparam int CW = $clog2(QW);

  state_e          state_q, state_d;
  logic [QW-1:0]   dvd_q, dvd_d;
  logic [BW-1:0]   dvs_q, dvs_d;
  logic [BW:0]     rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [BW-1:0]   remo_q, remo_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [BW+1:0]   trial;
  logic [BW:0]     sub;
  logic            qbit;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign trial = {rem_q, dvd_q[QW-1]};
  assign sub   = trial[BW:0] - {1'b0, dvs_q};
  assign qbit  = (trial >= {2'b00, dvs_q});

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (dvs_q == '0) begin
          quo_d   = '0;
          remo_d  = '0;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          qneg_d  = dvd_q[QW-1] ^ dvs_q[BW-1];
          rneg_d  = dvd_q[QW-1];
          dvd_d   = dvd_q[QW-1] ? -dvd_q : dvd_q;
          dvs_d   = dvs_q[BW-1] ? -dvs_q : dvs_q;
          rem_d   = '0;
          cnt_d   = CW'(QW - 1);
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = qbit ? sub : trial[BW:0];
        dvd_d = {dvd_q[QW-2:0], qbit};
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_DONE;
        dbz_d   = 1'b0;
        // Only -2^(QW-1) / -1 yields a magnitude with no positive encoding.
        if (dvd_q == {1'b1, {(QW-1){1'b0}}} && !qneg_q) begin
          quo_d  = {1'b0, {(QW-1){1'b1}}};
          remo_d = '0;
          ovf_d  = 1'b1;
        end else begin
          quo_d  = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q[BW-1:0] : rem_q[BW-1:0];
          ovf_d  = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomized checks of seq_div against an arithmetic model.
// Latency counted in edges after the start-sampling edge.
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] eq;
  logic [7:0]  er;
  logic        edz;
  logic        eov;
  int          elat;

  seq_div #(.BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: SV integer division truncates toward zero, % follows dividend.
  task automatic model(input logic [15:0] a, input logic [7:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      eq = 16'h0; er = 8'h0; edz = 1'b1; eov = 1'b0; elat = 2;
    end else if (ai == -32768 && bi == -1) begin
      eq = 16'h7FFF; er = 8'h0; edz = 1'b0; eov = 1'b1; elat = 19;
    end else begin
      eq = 16'(ai / bi); er = 8'(ai % bi);
      edz = 1'b0; eov = 1'b0; elat = 19;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [7:0] b, input bit poke);
    logic [15:0] pq;
    logic [7:0]  pr;
    logic        pdz, pov;
    bit          busy_ok, hold_ok;
    int          lat;
    pq = eq; pr = er; pdz = edz; pov = eov;
    busy_ok = 1; hold_ok = 1; lat = 0;
    model(a, b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) begin
        lat = k;
        break;
      end
      if (quotient !== pq || remainder !== pr ||
          div_by_zero !== pdz || overflow !== pov) hold_ok = 0;
      if (poke && k == 5) begin
        start = 1'b1; dividend = 16'h1234; divisor = 8'h03;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy"}, 32'(busy_ok), 1);
    chk({tag, " hold"}, 32'(hold_ok), 1);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " flags"}, {div_by_zero, overflow}, {edz, eov});
    @(negedge clk);
    chk({tag, " after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    bit saw_done;
    logic [15:0] ra;
    logic [7:0]  rb;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    eq = '0; er = '0; edz = 1'b0; eov = 1'b0; elat = 0;
    #2 rst = 1'b1;
    #1;
    chk("reset outs",
        {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("100/7", 16'd100, 8'd7, 0);
    chk("100/7 const", {quotient, remainder}, {16'h000E, 8'h02});
    run_op("-100/7", 16'hFF9C, 8'd7, 0);
    chk("-100/7 const", {quotient, remainder}, {16'hFFF2, 8'hFE});
    run_op("32767/-128", 16'h7FFF, 8'h80, 0);
    chk("32767/-128 const", {quotient, remainder}, {16'hFF01, 8'h7F});
    run_op("-32768/-1", 16'h8000, 8'hFF, 0);
    chk("ovf const", {quotient, remainder, overflow},
        {16'h7FFF, 8'h00, 1'b1});
    run_op("1234/0", 16'd1234, 8'h00, 0);
    chk("dbz const", {quotient, remainder, div_by_zero},
        {16'h0000, 8'h00, 1'b1});
    run_op("poke", 16'd100, 8'd7, 1);
    run_op("-32768/1", 16'h8000, 8'h01, 0);
    run_op("-32768/-128", 16'h8000, 8'h80, 0);

    // Abort an operation mid-divide with reset.
    @(negedge clk);
    start = 1'b1; dividend = 16'd5000; divisor = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset outs",
        {busy, done, quotient, remainder, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("midreset no done", 32'(saw_done), 0);
    eq = '0; er = '0; edz = 1'b0; eov = 1'b0;
    run_op("post-reset 100/7", 16'd100, 8'd7, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 4) == 0) ra = 16'h8000;
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: rb = 8'h80;
        2: rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
